// File: rtl/stream_inverse.sv
// Block-reversal stage: groups a free-running word stream into blocks of DEPTH
// and re-emits each block last-word-first through a two-bank ping-pong buffer.
module stream_inverse #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             ready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_bank [2][DEPTH];
  logic [AW-1:0]    r_widx;
  logic             r_sel;
  logic             r_primed;

  logic [AW-1:0]    w_ridx;
  logic             w_wrap;

  assign w_wrap = (r_widx == AW'(DEPTH - 1));
  // Read walks the idle bank backwards in lockstep with the write index
  assign w_ridx = AW'(DEPTH - 1) - r_widx;
  assign ready  = rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_widx   <= '0;
      r_sel    <= 1'b0;
      r_primed <= 1'b0;
    end else begin
      r_widx <= r_widx + AW'(1);
      if (w_wrap) begin
        r_sel    <= ~r_sel;
        r_primed <= 1'b1;
      end
    end
  end

  // Storage is not reset; stale contents are never read before being rewritten
  always_ff @(posedge clk) begin
    r_bank[r_sel][r_widx] <= in1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out   <= '0;
      valid <= 1'b0;
    end else if (r_primed) begin
      out   <= r_bank[~r_sel][w_ridx];
      valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_inverse.sv
// Self-checking bench for stream_inverse: DEPTH=4 and DEPTH=8 instances share one
// stream and are compared every cycle against a block-reversal reference model.
module tb_stream_inverse;

  logic        clk;
  logic        rst;
  logic [31:0] in1;
  logic [31:0] out4, out8;
  logic        valid4, valid8, ready4, ready8;

  int unsigned n_tests;
  int unsigned n_fail;
  int          cnt;
  logic [31:0] hist[$];

  stream_inverse #(.WIDTH(32), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in1(in1), .out(out4), .valid(valid4), .ready(ready4)
  );
  stream_inverse #(.WIDTH(32), .DEPTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in1(in1), .out(out8), .valid(valid8), .ready(ready8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, cnt);
    end
  endtask

  // Word d-block reversal puts on out after edge n (n counted from reset release)
  function automatic logic [31:0] exp_out(input int d, input int n);
    int blk;
    int pos;
    if (n < d) return 32'd0;
    blk = n / d - 1;
    pos = n % d;
    return hist[blk * d + (d - 1 - pos)];
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_out4"},   out4,          exp_out(4, cnt));
    check({tag, "_valid4"}, 32'(valid4),   (cnt >= 4) ? 32'd1 : 32'd0);
    check({tag, "_out8"},   out8,          exp_out(8, cnt));
    check({tag, "_valid8"}, 32'(valid8),   (cnt >= 8) ? 32'd1 : 32'd0);
    check({tag, "_ready"},  32'(ready4 & ready8), 32'd1);
  endtask

  // Called at a negedge: drive one word, check after the following rising edge
  task automatic step(input string tag, input logic [31:0] w);
    in1 = w;
    hist.push_back(w);
    @(posedge clk);
    #1;
    check_all(tag);
    cnt++;
    @(negedge clk);
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, "_out4"},  out4,                    32'd0);
    check({tag, "_out8"},  out8,                    32'd0);
    check({tag, "_valid"}, 32'(valid4 | valid8),    32'd0);
    check({tag, "_ready"}, 32'(ready4 | ready8),    32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cnt     = 0;
    rst     = 1'b0;
    in1     = 32'd0;

    // Held in reset
    repeat (10) begin
      @(negedge clk);
      check_in_reset("rst_hold");
    end

    // Release at a negedge and stream 1..12, then 40 random words without a break
    rst = 1'b1;
    for (int i = 1; i <= 12; i++) step("seq", 32'(i));
    for (int i = 0; i < 40; i++) step("rand", $urandom);

    // Extreme bit patterns
    step("pat", 32'hFFFF_FFFF);
    step("pat", 32'h8000_0000);
    step("pat", 32'h0000_0001);
    step("pat", 32'h7FFF_FFFF);
    for (int i = 0; i < 8; i++) step("pat_flush", $urandom);

    // Asynchronous reset partway through: fresh start, 6 words, then drop rst mid-phase
    rst = 1'b0;
    #1;
    hist.delete();
    cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) step("pre_arst", $urandom);
    #2;
    check("arst_precond_valid4", 32'(valid4), 32'd1);
    rst = 1'b0;
    #1;
    check_in_reset("arst_now");
    hist.delete();
    cnt = 0;
    repeat (2) begin
      @(negedge clk);
      check_in_reset("arst_hold");
    end
    rst = 1'b1;
    for (int i = 21; i <= 28; i++) step("restart", 32'(i));
    for (int i = 0; i < 16; i++) step("restart_rand", $urandom);

    // Several randomized bursts separated by resets of random length
    for (int b = 0; b < 4; b++) begin
      rst = 1'b0;
      #1;
      hist.delete();
      cnt = 0;
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        check_in_reset("burst_rst");
      end
      rst = 1'b1;
      repeat ($urandom_range(3, 30)) step("burst", $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
